// File: rtl/dac_update_scheduler.sv
// rtl/dac_update_scheduler.sv - coalescing two-channel DAC write scheduler with LDAC sequencing
module dac_update_scheduler #(
  parameter logic [15:0] ADDRESS_DAC0   = 16'hdac0,
  parameter logic [15:0] ADDRESS_DAC1   = 16'hdac1,
  parameter logic [15:0] ADDRESS_DAC_EN = 16'hdacf,
  parameter int unsigned ACK_TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch0_valid,
  input  logic [15:0] ch0_data,
  output logic        ch0_ready,
  input  logic        ch1_valid,
  input  logic [15:0] ch1_data,
  output logic        ch1_ready,
  input  logic        auto_load,
  input  logic        sw_load,
  input  logic        err_clr,
  output logic [31:0] dac_app_din,
  output logic        dac_app_req,
  input  logic        dac_app_ack,
  output logic        busy,
  output logic        load_done,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, GAP} state_t;

  localparam logic [31:0] ACK_LAST = 32'(ACK_TIMEOUT - 1);

  state_t      state;
  logic [15:0] shadow0;
  logic [15:0] shadow1;
  logic        pend0;
  logic        pend1;
  logic        load_pending;
  logic        rr_ptr;
  logic        cmd_is_load;
  logic [31:0] ack_cnt;

  logic        wr0;
  logic        wr1;
  logic        any_pend;
  logic        sel_ch;
  logic        pick_ch;
  logic        pick_ld;
  logic        ack_ok;
  logic        ack_tmo;

  // Channels can always absorb a write; writes simply overwrite the shadow.
  assign ch0_ready = ~rst;
  assign ch1_ready = ~rst;
  assign wr0       = ch0_valid & ch0_ready;
  assign wr1       = ch1_valid & ch1_ready;

  assign busy = (state != IDLE) | pend0 | pend1 | load_pending;

  // Round-robin choice between pending channels and the IDLE decisions.
  always_comb begin
    any_pend = pend0 | pend1;
    if (rr_ptr) sel_ch = pend1 ? 1'b1 : 1'b0;
    else        sel_ch = pend0 ? 1'b0 : 1'b1;
    pick_ch = (state == IDLE) & any_pend;
    pick_ld = (state == IDLE) & ~any_pend & load_pending;
    ack_ok  = (state == WAIT_ACK) & dac_app_ack;
    ack_tmo = (state == WAIT_ACK) & ~dac_app_ack & (ack_cnt == ACK_LAST);
  end

  // Shadow registers and pending bits; a new write wins over the clear on selection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow0 <= 16'h0000;
      shadow1 <= 16'h0000;
      pend0   <= 1'b0;
      pend1   <= 1'b0;
    end else begin
      if (wr0) begin
        shadow0 <= ch0_data;
        pend0   <= 1'b1;
      end else if (pick_ch && !sel_ch) begin
        pend0   <= 1'b0;
      end
      if (wr1) begin
        shadow1 <= ch1_data;
        pend1   <= 1'b1;
      end else if (pick_ch && sel_ch) begin
        pend1   <= 1'b0;
      end
    end
  end

  // LDAC request flag; any set in the same cycle as selection keeps one more LDAC queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_pending <= 1'b0;
    end else if (sw_load || (ack_ok && !cmd_is_load && auto_load)) begin
      load_pending <= 1'b1;
    end else if (pick_ld) begin
      load_pending <= 1'b0;
    end
  end

  // Sticky timeout flag; a fresh timeout beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (ack_tmo) begin
      timeout_err <= 1'b1;
    end else if (err_clr) begin
      timeout_err <= 1'b0;
    end
  end

  // Command sequencer: select, strobe, wait for ack (bounded), one-cycle gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dac_app_din <= 32'h0;
      dac_app_req <= 1'b0;
      load_done   <= 1'b0;
      ack_cnt     <= 32'h0;
      rr_ptr      <= 1'b0;
      cmd_is_load <= 1'b0;
    end else begin
      dac_app_req <= 1'b0;
      load_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_pend) begin
            rr_ptr      <= ~sel_ch;
            cmd_is_load <= 1'b0;
            dac_app_din <= sel_ch ? {ADDRESS_DAC1, shadow1} : {ADDRESS_DAC0, shadow0};
            dac_app_req <= 1'b1;
            state       <= ISSUE;
          end else if (load_pending) begin
            cmd_is_load <= 1'b1;
            dac_app_din <= {ADDRESS_DAC_EN, 16'h0000};
            dac_app_req <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          ack_cnt <= 32'h0;
          state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (dac_app_ack) begin
            load_done <= cmd_is_load;
            state     <= GAP;
          end else if (ack_cnt == ACK_LAST) begin
            state     <= GAP;
          end else begin
            ack_cnt   <= ack_cnt + 32'h1;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_update_scheduler.sv
// tb/tb_dac_update_scheduler.sv - scoreboard bench for dac_update_scheduler
module tb_dac_update_scheduler;

  localparam int ACK_TO = 16;
  localparam logic [15:0] A0 = 16'hdac0;
  localparam logic [15:0] A1 = 16'hdac1;
  localparam logic [15:0] AEN = 16'hdacf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ch0_valid = 1'b0, ch1_valid = 1'b0;
  logic [15:0] ch0_data = 16'h0, ch1_data = 16'h0;
  logic        ch0_ready, ch1_ready;
  logic        auto_load = 1'b0, sw_load = 1'b0, err_clr = 1'b0, dac_app_ack = 1'b0;
  logic [31:0] dac_app_din;
  logic        dac_app_req, busy, load_done, timeout_err;

  dac_update_scheduler #(.ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .rst(rst),
    .ch0_valid(ch0_valid), .ch0_data(ch0_data), .ch0_ready(ch0_ready),
    .ch1_valid(ch1_valid), .ch1_data(ch1_data), .ch1_ready(ch1_ready),
    .auto_load(auto_load), .sw_load(sw_load), .err_clr(err_clr),
    .dac_app_din(dac_app_din), .dac_app_req(dac_app_req), .dac_app_ack(dac_app_ack),
    .busy(busy), .load_done(load_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;
  bit spurious_en = 0;

  // scoreboard queues
  logic [31:0] exp_din[$];
  int          exp_edge[$];
  int          ld_q[$];
  int          dly_q[$];

  // reference model: transaction-level view with edge-number timing
  logic [15:0] m_shadow[2];
  bit          m_pend[2];
  bit          m_loadp, m_ptr, m_terr, m_tmo;
  int          m_cmd, m_sel_e, m_ack_edge, m_next_sel, m_fsm_end;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: actual=%0h required=%0h", name, edge_n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_shadow[0] = 16'h0; m_shadow[1] = 16'h0;
    m_pend[0] = 0; m_pend[1] = 0;
    m_loadp = 0; m_ptr = 0; m_terr = 0; m_tmo = 0; m_cmd = 0;
    m_sel_e = -10; m_ack_edge = -10; m_next_sel = 0; m_fsm_end = 0;
  endtask

  function automatic bit m_busy();
    return m_pend[0] || m_pend[1] || m_loadp || (edge_n < m_fsm_end);
  endfunction

  function automatic bit m_idle();
    return !m_pend[0] && !m_pend[1] && !m_loadp && (edge_n >= m_fsm_end);
  endfunction

  task automatic model_step(input int e);
    int  sel = -1;
    int  j;
    bit  ld_set = sw_load;
    bit  tmo_set = 0;
    if (e == m_ack_edge) begin
      if (m_tmo) tmo_set = 1;
      else if (m_cmd == 2) ld_q.push_back(e);
      else if (auto_load) ld_set = 1;
    end
    if (e >= m_next_sel) begin
      if (m_pend[0] || m_pend[1]) sel = m_ptr ? (m_pend[1] ? 1 : 0) : (m_pend[0] ? 0 : 1);
      else if (m_loadp) sel = 2;
    end
    if (sel >= 0) begin
      if (dly_q.size() > 0) j = dly_q.pop_front();
      else j = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(1, 6));
      m_tmo = (j < 0);
      if (m_tmo) j = ACK_TO;
      exp_din.push_back(sel == 2 ? {AEN, 16'h0000} : {(sel == 1) ? A1 : A0, m_shadow[sel]});
      exp_edge.push_back(e);
      m_cmd = sel; m_sel_e = e; m_ack_edge = e + 1 + j;
      m_next_sel = e + j + 3; m_fsm_end = e + j + 2;
      if (sel < 2) begin m_pend[sel] = 0; m_ptr = (sel == 0); end
      else m_loadp = 0;
    end
    if (ch0_valid) begin m_shadow[0] = ch0_data; m_pend[0] = 1; end
    if (ch1_valid) begin m_shadow[1] = ch1_data; m_pend[1] = 1; end
    if (ld_set) m_loadp = 1;
    if (tmo_set) m_terr = 1;
    else if (err_clr) m_terr = 0;
  endtask

  // one clock: drive ack from the model, advance model, clock, clear pulses, check levels
  task automatic tick();
    int e = edge_n + 1;
    dac_app_ack = (e == m_ack_edge && !m_tmo) ? 1'b1 : 1'b0;
    if (spurious_en && !dac_app_ack && !(e > m_sel_e + 1 && e <= m_ack_edge)
        && $urandom_range(0, 7) == 0) dac_app_ack = 1'b1;
    model_step(e);
    @(posedge clk);
    edge_n++;
    #1;
    ch0_valid = 0; ch1_valid = 0; sw_load = 0; err_clr = 0; dac_app_ack = 0;
    check("busy", busy, m_busy());
    check("timeout_err", timeout_err, m_terr);
  endtask

  task automatic write(input bit c0, input logic [15:0] d0, input bit c1, input logic [15:0] d1);
    ch0_valid = c0; ch0_data = d0;
    ch1_valid = c1; ch1_data = d1;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && !m_idle(); i++) tick();
    check("drain_idle", m_idle(), 1);
    repeat (3) tick();
    check("req_queue_empty", exp_din.size(), 0);
    check("load_queue_empty", ld_q.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_din"}, dac_app_din, 0);
    check({tag, "_req"}, dac_app_req, 0);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, {ch0_ready, ch1_ready}, 0);
  endtask

  // asynchronous reset asserted between edges; in-flight commands are lost
  task automatic mid_reset();
    rst = 1;
    #1;
    check_zero_outputs("midrst");
    exp_din.delete(); exp_edge.delete(); ld_q.delete(); dly_q.delete();
    @(posedge clk);
    edge_n++;
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (dac_app_req) begin
          if (exp_din.size() == 0) begin
            check("unexpected_req", dac_app_din, 0);
            check("unexpected_req_flag", 1, 0);
          end else begin
            check("req_din", dac_app_din, exp_din.pop_front());
            check("req_edge", edge_n, exp_edge.pop_front());
          end
        end
        if (load_done) begin
          if (ld_q.size() == 0) check("unexpected_load_done", 1, 0);
          else check("load_done_edge", edge_n, ld_q.pop_front());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    fork monitor(); join_none
    repeat (2) begin @(posedge clk); edge_n++; end
    #1;
    check_zero_outputs("reset");
    rst = 0;
    #1;
    check("ready_after_reset", {ch0_ready, ch1_ready}, 2'b11);

    // both channels in one cycle with auto_load: ch0, ch1, one LDAC
    auto_load = 1;
    dly_q.push_back(2); dly_q.push_back(3); dly_q.push_back(1);
    write(1, 16'h0011, 1, 16'h0022);
    drain();

    // single ch0 write, ack 5 cycles after req, no LDAC
    auto_load = 0;
    dly_q.push_back(5);
    write(1, 16'h00A5, 0, 16'h0);
    drain();

    // ch1 written three times while ch0 awaits ack
    dly_q.push_back(8); dly_q.push_back(2);
    write(1, 16'h1234, 0, 16'h0);
    write(0, 16'h0, 1, 16'h0001);
    write(0, 16'h0, 1, 16'h0002);
    write(0, 16'h0, 1, 16'h0003);
    drain();

    // ch0 times out, ch1 still issues, then err_clr
    dly_q.push_back(-1); dly_q.push_back(2);
    write(1, 16'h0BAD, 0, 16'h0);
    write(0, 16'h0, 1, 16'h0C0D);
    drain();
    check("timeout_seen", timeout_err, 1);
    err_clr = 1;
    tick();
    check("timeout_cleared", timeout_err, 0);

    // write to ch0 on the very edge ch0 is selected
    dly_q.push_back(4); dly_q.push_back(2); dly_q.push_back(2);
    write(0, 16'h0, 1, 16'h1111);
    write(1, 16'h0AAA, 0, 16'h0);
    for (int i = 0; i < 40 && (edge_n + 1) != m_next_sel; i++) tick();
    check("collision_reached", edge_n + 1, m_next_sel);
    write(1, 16'h0BBB, 0, 16'h0);
    drain();

    // sw_load on the LDAC selection edge leaves one more LDAC
    dly_q.push_back(2); dly_q.push_back(2);
    sw_load = 1; tick();
    sw_load = 1; tick();
    drain();

    // reset during WAIT_ACK with ch1 pending; nothing issues afterwards
    dly_q.push_back(10);
    write(1, 16'h5555, 0, 16'h0);
    write(0, 16'h0, 1, 16'h6666);
    repeat (3) tick();
    mid_reset();
    repeat (12) tick();
    check("post_reset_no_req", exp_din.size(), 0);

    // randomized traffic
    spurious_en = 1;
    for (int i = 0; i < 600; i++) begin
      ch0_valid = ($urandom_range(0, 3) == 0);
      ch0_data  = 16'($urandom);
      ch1_valid = ($urandom_range(0, 3) == 0);
      ch1_data  = 16'($urandom);
      sw_load   = ($urandom_range(0, 19) == 0);
      err_clr   = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 29) == 0) auto_load = ~auto_load;
      tick();
    end
    spurious_en = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
